// File: rtl/spi_rom_pkg.sv
// rtl/spi_rom_pkg.sv - shared opcodes, phase lengths and state encoding for the SPI ROM streamer
package spi_rom_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DUMMY_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        FINISH
    } state_t;

endpackage

// File: rtl/spi_rom_sck_gen.sv
// rtl/spi_rom_sck_gen.sv - SPI mode-0 clock divider with single-cycle rise/fall/tick strobes
module spi_rom_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic allow_rise,
    output logic sck,
    output logic rise,
    output logic fall,
    output logic tick
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    // Strobes mark the clk edge at which sck changes, so users act on the same edge.
    always_comb begin
        tick = en && (cnt == TERM);
        rise = tick && !sck && allow_rise;
        fall = tick && sck;
    end

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 8'd1;
            if (rise) begin
                sck <= 1'b1;
            end else if (fall) begin
                sck <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_rom_streamer.sv
// rtl/spi_rom_streamer.sv - streams bytes from SPI flash (READ 0x03, or FAST_READ 0x0B with SPI_ROM_FAST_READ_EN)
module spi_rom_streamer #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [23:0]       base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [7:0]        byte_out,
    output logic              byte_strobe,
    output logic              busy,
    output logic              done
);

    import spi_rom_pkg::*;

`ifdef SPI_ROM_FAST_READ_EN
    localparam logic [7:0] OPCODE    = OP_FAST_READ;
    localparam state_t     AFTER_ADDR = DUMMY;
`else
    localparam logic [7:0] OPCODE    = OP_READ;
    localparam state_t     AFTER_ADDR = DATA;
`endif

    localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
    localparam logic [4:0] ADDR_LAST  = 5'(ADDR_BITS - 1);
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_BITS - 1);

    state_t            state;
    state_t            state_next;
    logic [30:0]       tx_shift;
    logic [6:0]        rx_shift;
    logic [4:0]        bit_cnt;
    logic [ADDR_W-1:0] remaining;

    logic sck_en;
    logic sck_allow_rise;
    logic sck_rise;
    logic sck_fall;
    logic sck_tick;

    logic accept;
    logic zero_start;
    logic phase_end;
    logic byte_done;
    logic finish_exit;

    spi_rom_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (sck_en),
        .allow_rise(sck_allow_rise),
        .sck       (spi_sck),
        .rise      (sck_rise),
        .fall      (sck_fall),
        .tick      (sck_tick)
    );

    // FINISH keeps the divider running so the final high phase completes as a full
    // half-period, then one more low half-period elapses before chip select is released.
    assign sck_en         = (state != IDLE);
    assign sck_allow_rise = (state != FINISH);

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        zero_start  = 1'b0;
        phase_end   = 1'b0;
        byte_done   = 1'b0;
        finish_exit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        accept     = 1'b1;
                        state_next = CMD;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            CMD: begin
                if (sck_rise && bit_cnt == CMD_LAST) begin
                    phase_end  = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (sck_rise && bit_cnt == ADDR_LAST) begin
                    phase_end  = 1'b1;
                    state_next = AFTER_ADDR;
                end
            end
            DUMMY: begin
                if (sck_rise && bit_cnt == DUMMY_LAST) begin
                    phase_end  = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (sck_rise && bit_cnt[2:0] == 3'd7) begin
                    byte_done = 1'b1;
                    if (remaining == ADDR_W'(1)) begin
                        state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                if (sck_tick && !spi_sck) begin
                    finish_exit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spi_cs_n    <= 1'b1;
            spi_mosi    <= 1'b0;
            byte_out    <= '0;
            byte_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            remaining   <= '0;
        end else begin
            byte_strobe <= byte_done;
            done        <= zero_start || finish_exit;
            busy        <= (state_next != IDLE) || finish_exit;

            if (accept) begin
                spi_cs_n  <= 1'b0;
                spi_mosi  <= OPCODE[7];
                tx_shift  <= {OPCODE[6:0], base_addr};
                bit_cnt   <= '0;
                remaining <= length;
            end
            if (finish_exit) begin
                spi_cs_n <= 1'b1;
            end

            if (sck_rise) begin
                bit_cnt  <= phase_end ? 5'd0 : bit_cnt + 5'd1;
                rx_shift <= {rx_shift[5:0], spi_miso};
            end
            if (byte_done) begin
                byte_out  <= {rx_shift, spi_miso};
                remaining <= remaining - ADDR_W'(1);
            end

            // The fall after the last address bit already lands in DUMMY/DATA, parking MOSI low.
            if (sck_fall) begin
                tx_shift <= {tx_shift[29:0], 1'b0};
                spi_mosi <= (state == CMD || state == ADDR) ? tx_shift[30] : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rom_streamer.sv
// tb/tb_spi_rom_streamer.sv - directed scoreboard bench for spi_rom_streamer with a behavioural flash
module tb_spi_rom_streamer;

    localparam int CLK_DIV = 2;
    localparam int ADDR_W  = 22;

`ifdef SPI_ROM_FAST_READ_EN
    localparam logic [7:0] EXP_OP      = 8'h0B;
    localparam int         DUMMY_RISES = 8;
`else
    localparam logic [7:0] EXP_OP      = 8'h03;
    localparam int         DUMMY_RISES = 0;
`endif
    localparam int PRE_BITS = 32 + DUMMY_RISES;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [23:0]       base_addr;
    logic [ADDR_W-1:0] length;
    logic              spi_cs_n;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso = 1'b0;
    logic [7:0]        byte_out;
    logic              byte_strobe;
    logic              busy;
    logic              done;

    spi_rom_streamer #(
        .CLK_DIV(CLK_DIV),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .byte_out   (byte_out),
        .byte_strobe(byte_strobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h010000: return 8'hA5;
            24'h010001: return 8'h3C;
            24'h010002: return 8'hFF;
            default:    return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    // Flash model: captures opcode+address on SCK rises, drives data on SCK falls.
    int          rise_cnt  = 0;
    int          last_total = 0;
    int          mosi_late = 0;
    logic [31:0] hdr       = 32'h0;
    int          fidx;
    logic [7:0]  fbyte;

    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            last_total = rise_cnt;
            rise_cnt   = 0;
        end else begin
            if (rise_cnt < 32) hdr = {hdr[30:0], spi_mosi};
            else if (spi_mosi) mosi_late++;
            rise_cnt++;
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_cs_n && rise_cnt >= PRE_BITS) begin
            fidx     = rise_cnt - PRE_BITS;
            fbyte    = flash_byte(hdr[23:0] + 24'(fidx / 8));
            spi_miso = fbyte[7 - (fidx % 8)];
        end
    end

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         strobe_cnt  = 0;
    int         done_cnt    = 0;
    int         prev_strobe = -1;
    int         last_strobe = 0;
    int         last_done   = 0;
    int         busy_seen   = 0;
    int         cs_low_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (busy) busy_seen++;
        if (!spi_cs_n) cs_low_seen++;
        if (done) begin
            done_cnt++;
            last_done = cyc;
        end
        if (byte_strobe) begin
            strobe_cnt++;
            last_strobe = cyc;
            if (prev_strobe >= 0) check("strobe_spacing", 32'(cyc - prev_strobe), 32'(16 * CLK_DIV));
            prev_strobe = cyc;
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                check("byte_out", {24'h0, byte_out}, {24'h0, exp_b});
            end
        end
    endtask

    task automatic clear_counts();
        strobe_cnt  = 0;
        done_cnt    = 0;
        prev_strobe = -1;
        busy_seen   = 0;
        cs_low_seen = 0;
        mosi_late   = 0;
    endtask

    task automatic start_stream(input logic [23:0] a, input logic [ADDR_W-1:0] n);
        start     = 1'b1;
        base_addr = a;
        length    = n;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int bound);
        int n;
        int d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < bound) begin
            step();
            n++;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        repeat (3) step();
        check("rst_cs_n", {31'h0, spi_cs_n}, 32'd1);
        check("rst_sck", {31'h0, spi_sck}, 32'd0);
        check("rst_mosi", {31'h0, spi_mosi}, 32'd0);
        check("rst_byte_out", {24'h0, byte_out}, 32'd0);
        check("rst_strobe", {31'h0, byte_strobe}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        reset = 1'b0;
        step();

        // Basic read of three known bytes.
        clear_counts();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hFF);
        start_stream(24'h010000, 3);
        check("t1_cs_low", {31'h0, spi_cs_n}, 32'd0);
        check("t1_busy", {31'h0, busy}, 32'd1);
        run_until_done(2000);
        check("t1_busy_at_done", {31'h0, busy}, 32'd1);
        check("t1_cs_high", {31'h0, spi_cs_n}, 32'd1);
        check("t1_done_lag", 32'(last_done - last_strobe), 32'(2 * CLK_DIV));
        step();
        check("t1_busy_after", {31'h0, busy}, 32'd0);
        check("t1_done_pulse", {31'h0, done}, 32'd0);
        check("t1_header", hdr, {EXP_OP, 24'h010000});
        check("t1_rises", 32'(last_total), 32'(PRE_BITS + 24));
        check("t1_mosi_low", 32'(mosi_late), 32'd0);
        check("t1_strobes", 32'(strobe_cnt), 32'd3);
        check("t1_dones", 32'(done_cnt), 32'd1);

        // Four bytes, spacing checked in step, silence afterwards.
        clear_counts();
        for (int i = 0; i < 4; i++) exp_q.push_back(flash_byte(24'h020010 + 24'(i)));
        start_stream(24'h020010, 4);
        run_until_done(2000);
        repeat (200) step();
        check("t2_strobes", 32'(strobe_cnt), 32'd4);
        check("t2_dones", 32'(done_cnt), 32'd1);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero length: done only, no chip select, no busy.
        clear_counts();
        start_stream(24'h010000, 0);
        check("t3_done_next", {31'h0, done}, 32'd1);
        repeat (20) step();
        check("t3_busy_never", 32'(busy_seen), 32'd0);
        check("t3_cs_never_low", 32'(cs_low_seen), 32'd0);
        check("t3_dones", 32'(done_cnt), 32'd1);

        // Start while busy is ignored.
        clear_counts();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        start_stream(24'h010000, 2);
        repeat (40) step();
        start_stream(24'h030000, 5);
        run_until_done(2000);
        repeat (100) step();
        check("t4_strobes", 32'(strobe_cnt), 32'd2);
        check("t4_dones", 32'(done_cnt), 32'd1);
        check("t4_header", hdr, {EXP_OP, 24'h010000});

        // Reset after the first byte aborts the stream.
        clear_counts();
        for (int i = 0; i < 5; i++) exp_q.push_back(flash_byte(24'h010000 + 24'(i)));
        start_stream(24'h010000, 5);
        for (int n = 0; n < 1000 && strobe_cnt == 0; n++) step();
        check("t5_first_strobe", 32'(strobe_cnt), 32'd1);
        reset = 1'b1;
        step();
        check("t5_cs_high", {31'h0, spi_cs_n}, 32'd1);
        check("t5_sck_low", {31'h0, spi_sck}, 32'd0);
        check("t5_busy_low", {31'h0, busy}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (300) step();
        check("t5_strobes", 32'(strobe_cnt), 32'd1);
        check("t5_dones", 32'(done_cnt), 32'd0);

        // Single byte: opcode and dummy cycles follow the build configuration.
        clear_counts();
        exp_q.push_back(8'hA5);
        start_stream(24'h010000, 1);
        run_until_done(2000);
        step();
        check("t6_opcode", {24'h0, hdr[31:24]}, {24'h0, EXP_OP});
        check("t6_rises", 32'(last_total), 32'(PRE_BITS + 8));
        check("t6_strobes", 32'(strobe_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_rom_streamer.md
SPI_ROM_STREAMER -- requirements
Module: spi_rom_streamer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per SCK half-period; legal range 1..255.
REQ-002 SHALL have parameter ADDR_W, default 22: width of length input and byte counter.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a stream.
REQ-006 SHALL have port base_addr  input  24  flash byte address of first ROM byte, sampled on accepted start.
REQ-007 SHALL have port length  input  ADDR_W  number of bytes to stream, sampled on accepted start.
REQ-008 SHALL have port spi_cs_n  output  1  flash chip select, active low.
REQ-009 SHALL have port spi_sck  output  1  SPI clock, mode 0 (idle low).
REQ-010 SHALL have port spi_mosi  output  1  serial data to flash, MSB first.
REQ-011 SHALL have port spi_miso  input  1  serial data from flash.
REQ-012 SHALL have port byte_out  output  8  last received ROM byte, held until next byte.
REQ-013 SHALL have port byte_strobe  output  1  one-cycle pulse per received byte; drives the loader's indata_clk.
REQ-014 SHALL have ports busy (output, 1: stream in progress) and done (output, 1: one-cycle pulse at stream end).

Function
REQ-015 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, FINISH.
REQ-016 SHALL accept start only in IDLE; start while busy is ignored with no effect.
REQ-017 SHALL, on accepted start with length != 0, drive spi_cs_n low in the next cycle and enter CMD.
REQ-018 SHALL, on accepted start with length == 0, never assert spi_cs_n low, pulse done the next cycle and remain in IDLE.
REQ-019 SHALL toggle spi_sck every CLK_DIV clk cycles while in CMD/ADDR/DUMMY/DATA, never while spi_cs_n is high.
REQ-020 SHALL change spi_mosi only on SCK falling edges (first bit set up before the first rising edge) and sample spi_miso on SCK rising edges.
REQ-021 CMD SHALL shift opcode 8 bits; ADDR SHALL shift base_addr[23:0] MSB first, then go to DUMMY (macro on) or DATA.
REQ-022 DATA SHALL assemble 8 sampled bits MSB first; byte_strobe SHALL pulse exactly one cycle after the 8th rising edge, with byte_out valid in that same cycle.
REQ-023 SHALL hold spi_mosi low during DUMMY and DATA.
REQ-024 SHALL decrement a remaining-byte counter on each byte_strobe; at zero, enter FINISH.
REQ-025 FINISH SHALL return spi_sck low, hold spi_cs_n low for one further SCK half-period, then drive spi_cs_n high, pulse done, and enter IDLE.
REQ-026 busy SHALL be high from the cycle after accepted start through the cycle done pulses, low otherwise.
REQ-027 Consecutive byte_strobe pulses SHALL be separated by exactly 16*CLK_DIV clk cycles (continuous SCK, no per-byte gaps).
REQ-028 Byte counter SHALL be ADDR_W bits; length = 2^ADDR_W-1 SHALL stream fully without wrap; flash address wrap above 0xFFFFFF is the flash's behaviour, not tracked.

Reset
REQ-029 On reset: state IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, byte_out=0, byte_strobe=0, busy=0, done=0, counters 0.
REQ-030 Reset mid-stream SHALL abort in the following cycle: spi_cs_n high, no further byte_strobe, no done pulse.

Configuration
REQ-031 With macro SPI_ROM_FAST_READ_EN defined: opcode 0x0B, DUMMY state shifts 8 SCK cycles before DATA.
REQ-032 Without SPI_ROM_FAST_READ_EN: opcode 0x03, DUMMY state is never entered (ADDR goes straight to DATA).

Structure
REQ-033 Shared package spi_rom_pkg SHALL hold opcodes (OP_READ=0x03, OP_FAST_READ=0x0B) and the state enum.
REQ-034 One sub-module spi_rom_sck_gen SHALL generate spi_sck and single-cycle rise/fall strobes from CLK_DIV.

Verification
REQ-035 Flash model holds 0xA5,0x3C,0xFF at 0x010000; start, base_addr=0x010000, length=3 -> MOSI 0x03,0x01,0x00,0x00; three strobes carrying 0xA5,0x3C,0xFF; one done pulse; cs_n high.
REQ-036 CLK_DIV=2, length=4 -> strobe spacing exactly 32 clk cycles; zero strobes after counter reaches 0.
REQ-037 length=0 -> spi_cs_n stays 1, done pulses one cycle after start, busy never rises.
REQ-038 start pulsed again while busy with length=2 streaming -> ignored; exactly 2 strobes total.
REQ-039 reset asserted after 1st strobe of length=5 -> next cycle cs_n=1, sck=0, no more strobes, no done.
REQ-040 SPI_ROM_FAST_READ_EN defined, length=1 -> opcode 0x0B, 8 dummy SCK cycles, then one strobe with correct byte.
